// File: rtl/spm_pkg.sv
// Shared constants and arithmetic helpers for the streaming pattern matcher.
package spm_pkg;

    localparam logic SPM_INDEP = 1'b0;
    localparam logic SPM_CONT  = 1'b1;

    // Widest match vector the popcount helper accepts.
    localparam int POP_MAX_W = 256;

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[63:0];
    endfunction

    function automatic logic sat_over(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input logic [63:0] max);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max});
    endfunction

    function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {8'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_pattern_match_if.sv
// Input word handshake plus result/statistics bundle of the pattern matcher.
interface stream_pattern_match_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    localparam int HITS_W = $clog2(DATA_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_match;
    logic [HITS_W-1:0] out_hits;
    logic [CNT_W-1:0]  match_count;
    logic              count_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_match, out_hits, match_count, count_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_match, out_hits, match_count, count_sat
    );
endinterface

// File: rtl/stream_pattern_match_window_match.sv
// One window compare: hit when every cared-about bit equals the pattern.
module window_match #(
    parameter int PAT_W = 4
) (
    input  logic [PAT_W-1:0] win_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [PAT_W-1:0] care_i,
    output logic             hit_o
);
    assign hit_o = &(~(win_i ^ pat_i) | ~care_i);
endmodule

// File: rtl/stream_pattern_match.sv
// Streaming masked pattern matcher: per-word match vector, hit count and
// saturating running total behind a one-entry output buffer.
module stream_pattern_match
    import spm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_care,
    input  logic             cfg_cont,
    stream_pattern_match_if.slave bus
);
    localparam int EXT_W  = DATA_W + PAT_W - 1;
    localparam int TAIL_W = PAT_W - 1;
    localparam int HITS_W = $clog2(DATA_W + 1);
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [PAT_W-1:0]  pat_q, care_q;
    logic              cont_q;
    logic [TAIL_W-1:0] tail_q;
    logic              tail_vld_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] match_q;
    logic [HITS_W-1:0] hits_q;
    logic [CNT_W-1:0]  count_q;
    logic              sat_q;

    logic [EXT_W-1:0]  ext;
    logic [DATA_W-1:0] raw_hit, match_d;
    logic [HITS_W-1:0] hits_d;
    logic [CNT_W-1:0]  count_d;
    logic              sat_d;
    logic              in_ready, accept;

    assign ext = {bus.in_data, tail_q};

    for (genvar i = 0; i < DATA_W; i++) begin : g_win
        window_match #(.PAT_W(PAT_W)) u_win (
            .win_i  (ext[i +: PAT_W]),
            .pat_i  (pat_q),
            .care_i (care_q),
            .hit_o  (raw_hit[i])
        );
    end

    // Low positions reach into the previous word; only trust them in
    // continuous mode once a word has actually been seen.
    always_comb begin
        match_d = raw_hit;
        if (!(cont_q == SPM_CONT && tail_vld_q)) begin
            match_d[TAIL_W-1:0] = '0;
        end
    end

    assign hits_d  = HITS_W'(popcount(POP_MAX_W'(match_d)));
    assign count_d = CNT_W'(sat_add(64'(count_q), 64'(hits_d), CNT_MAX));
    assign sat_d   = sat_over(64'(count_q), 64'(hits_d), CNT_MAX);

    assign in_ready = !cfg_we && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q       <= '0;
            care_q      <= '0;
            cont_q      <= SPM_INDEP;
            tail_q      <= '0;
            tail_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            match_q     <= '0;
            hits_q      <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (cfg_we) begin
                pat_q      <= cfg_pattern;
                care_q     <= cfg_care;
                cont_q     <= cfg_cont;
                tail_vld_q <= 1'b0;
                count_q    <= '0;
                sat_q      <= 1'b0;
            end
            if (accept) begin
                tail_q      <= bus.in_data[DATA_W-1 -: TAIL_W];
                tail_vld_q  <= 1'b1;
                match_q     <= match_d;
                hits_q      <= hits_d;
                count_q     <= count_d;
                sat_q       <= sat_q | sat_d;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_match   = match_q;
    assign bus.out_hits    = hits_q;
    assign bus.match_count = count_q;
    assign bus.count_sat   = sat_q;

endmodule
